arbitro_rr_param: RTL and testbench

Parametrised successor of the 4-in/4-out arbiter. It arbitrates N_SRC source FIFOs (naranja side) into N_DST destination FIFOs (morado side). Each cycle it pops at most one source, chosen round-robin, and pushes the popped word one cycle later into the destination selected by the word's top bits. It sits between the input FIFO bank and the output FIFO bank and is enabled by the top-level state machine's state code.

---
 rtl/arbitro_rr_param.sv | 147 ++++++++++++++
 tb/tb_arbitro_rr_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_param.sv
// rtl/arbitro_rr_param.sv - N_SRC-to-N_DST FIFO arbiter, round-robin by default; define ARB_FIXED_PRIO_EN for fixed priority
module arbitro_rr_param #(
  parameter int                 N_SRC        = 4,
  parameter int                 N_DST        = 4,
  parameter int                 DATA_W       = 6,
  parameter int                 STATE_W      = 4,
  parameter logic [STATE_W-1:0] ACTIVE_STATE = STATE_W'(4'b0100)
) (
  input  logic                      clk,
  input  logic                      reset_L,
  input  logic [STATE_W-1:0]        state,
  input  logic [N_SRC-1:0]          empty_src,
  input  logic [N_SRC*DATA_W-1:0]   data_src,
  input  logic [N_DST-1:0]          almost_full_dst,
  input  logic [N_DST-1:0]          empty_dst,
  output logic [N_SRC-1:0]          pop,
  output logic [N_DST-1:0]          push,
  output logic [DATA_W-1:0]         data_out,
  output logic [N_SRC+N_DST-1:0]    empties,
  output logic                      idle
);

  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DST_W = $clog2(N_DST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fsm_e;

  fsm_e                     fsm_q, fsm_d;
  logic                     en, stall, pop_ok;
  logic                     gnt_vld;
  logic [SRC_W-1:0]         gnt_idx;
  logic                     v_q, v_d;
  logic [SRC_W-1:0]         g_q, g_d;
  logic [N_SRC+N_DST-1:0]   empties_q, empties_d;
  logic [DATA_W-1:0]        word;
  logic [DST_W-1:0]         dst;

  assign en    = (state == ACTIVE_STATE);
  assign stall = |almost_full_dst;

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) fsm_q <= ST_IDLE;
    else          fsm_q <= fsm_d;
  end

  // FSM next state: disable always wins, stall toggles RUN/STALL
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE:  if (en) fsm_d = ST_RUN;
      ST_RUN:   if (!en) fsm_d = ST_IDLE; else if (stall) fsm_d = ST_STALL;
      ST_STALL: if (!en) fsm_d = ST_IDLE; else if (!stall) fsm_d = ST_RUN;
      default:  fsm_d = ST_IDLE;
    endcase
  end

  // FSM output: pops only from RUN with the live enable and no live stall
  always_comb begin
    pop_ok = (fsm_q == ST_RUN) && en && !stall;
  end

`ifdef ARB_FIXED_PRIO_EN
  // Grant: lowest non-empty source index
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N_SRC; k++) begin
      if (!gnt_vld && !empty_src[k]) begin
        gnt_vld = 1'b1;
        gnt_idx = k[SRC_W-1:0];
      end
    end
  end
`else
  logic [SRC_W-1:0] last_q;

  // Grant: first non-empty source after the last one served, wrapping
  always_comb begin
    int cand;
    cand    = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = (int'(last_q) + k) % N_SRC;
      if (!gnt_vld && !empty_src[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[SRC_W-1:0];
      end
    end
  end

  // Round-robin pointer advances only when a pop actually happens
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)     last_q <= SRC_W'(N_SRC - 1);
    else if (|pop)    last_q <= gnt_idx;
  end
`endif

  // One-hot pop toward the granted source
  always_comb begin
    pop = '0;
    if (pop_ok && gnt_vld) pop[gnt_idx] = 1'b1;
  end

  assign v_d       = |pop;
  assign g_d       = gnt_idx;
  assign empties_d = {empty_dst, empty_src};

  // In-flight word tracking and registered empty flags; reset drops a pending push
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      v_q       <= 1'b0;
      g_q       <= '0;
      empties_q <= '1;
    end else begin
      v_q       <= v_d;
      g_q       <= g_d;
      empties_q <= empties_d;
    end
  end

  // Select the read word of the source popped last cycle
  always_comb begin
    word = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (g_q == i[SRC_W-1:0]) word = data_src[i*DATA_W +: DATA_W];
    end
  end

  assign data_out = v_q ? word : '0;
  assign dst      = data_out[DATA_W-1 -: DST_W];

  // One-hot push toward the destination named by the word's top bits
  always_comb begin
    push = '0;
    if (v_q) push[dst] = 1'b1;
  end

  assign empties = empties_q;
  assign idle    = !reset_L || (!v_q && (&empty_src));

endmodule

// File: tb/tb_arbitro_rr_param.sv
// tb/tb_arbitro_rr_param.sv - randomized self-checking bench for arbitro_rr_param against a behavioural model
module tb_arbitro_rr_param;

  localparam int NS  = 4;
  localparam int ND  = 4;
  localparam int DW  = 6;
  localparam logic [3:0] ACT = 4'b0100;

  logic            clk = 1'b0;
  logic            reset_L;
  logic [3:0]      state;
  logic [NS-1:0]   empty_src;
  logic [NS*DW-1:0] data_src;
  logic [ND-1:0]   almost_full_dst;
  logic [ND-1:0]   empty_dst;
  logic [NS-1:0]   pop;
  logic [ND-1:0]   push;
  logic [DW-1:0]   data_out;
  logic [NS+ND-1:0] empties;
  logic            idle;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_last;
  bit          m_v;
  int          m_g;
  bit          m_run;
  bit          m_fidle;
  logic [7:0]  m_emp;
  logic [DW-1:0] words [NS];

  arbitro_rr_param #(
    .N_SRC(NS), .N_DST(ND), .DATA_W(DW), .STATE_W(4), .ACTIVE_STATE(ACT)
  ) dut (
    .clk(clk), .reset_L(reset_L), .state(state), .empty_src(empty_src),
    .data_src(data_src), .almost_full_dst(almost_full_dst), .empty_dst(empty_dst),
    .pop(pop), .push(push), .data_out(data_out), .empties(empties), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [NS-1:0] es, input int last);
`ifdef ARB_FIXED_PRIO_EN
    for (int k = 0; k < NS; k++) if (!es[k]) return k;
`else
    for (int k = 1; k <= NS; k++) begin
      int c;
      c = (last + k) % NS;
      if (!es[c]) return c;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_last  = NS - 1;
    m_v     = 0;
    m_g     = 0;
    m_run   = 0;
    m_fidle = 1;
    m_emp   = '1;
  endtask

  // drive one cycle of inputs, check outputs against the model, advance the model
  task automatic step(input logic rl, input logic [3:0] st, input logic [NS-1:0] es,
                      input logic [ND-1:0] af, input logic [ND-1:0] ed);
    bit en, stall;
    int gsel;
    logic [NS-1:0] e_pop;
    logic [ND-1:0] e_push;
    logic [DW-1:0] e_do;
    logic [7:0]    e_emp;
    logic          e_idle;
    @(negedge clk);
    reset_L = rl; state = st; empty_src = es; almost_full_dst = af; empty_dst = ed;
    for (int i = 0; i < NS; i++) begin
      words[i] = DW'($urandom);
      data_src[i*DW +: DW] = words[i];
    end
    #1;
    en    = (st == ACT);
    stall = |af;
    if (!rl) begin
      gsel = -1; e_pop = '0; e_push = '0; e_do = '0; e_emp = '1; e_idle = 1'b1;
    end else begin
      gsel   = (m_run && en && !stall) ? pick(es, m_last) : -1;
      e_pop  = (gsel >= 0) ? NS'(1 << gsel) : '0;
      e_do   = m_v ? words[m_g] : '0;
      e_push = m_v ? ND'(1 << e_do[DW-1 -: 2]) : '0;
      e_emp  = m_emp;
      e_idle = !m_v && (&es);
    end
    chk("pop", 32'(pop), 32'(e_pop));
    chk("push", 32'(push), 32'(e_push));
    chk("data_out", 32'(data_out), 32'(e_do));
    chk("empties", 32'(empties), 32'(e_emp));
    chk("idle", 32'(idle), 32'(e_idle));
    if (!rl) begin
      model_reset();
    end else begin
      m_v = (gsel >= 0);
      if (gsel >= 0) begin
        m_g    = gsel;
        m_last = gsel;
      end
      m_emp   = {ed, es};
      m_run   = en && (m_fidle || !stall);
      m_fidle = !en;
    end
  endtask

  initial begin
    reset_L = 1'b0; state = '0; empty_src = '1; data_src = '0;
    almost_full_dst = '0; empty_dst = '1;
    model_reset();

    // reset, then active with everything empty
    step(1'b0, ACT, 4'hF, 4'h0, 4'hF);
    step(1'b0, ACT, 4'hF, 4'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ACT, 4'hF, 4'h0, 4'hF);
      chk("idle_all_empty", 32'(idle), 32'd1);
      chk("empties_ff", 32'(empties), 32'hFF);
      chk("no_pop_empty", 32'(pop), 32'd0);
    end

`ifndef ARB_FIXED_PRIO_EN
    // all sources busy: rotating one-hot pops starting at source 0
    for (int k = 0; k < 8; k++) begin
      step(1'b1, ACT, 4'h0, 4'h0, 4'h0);
      chk("rr_seq", 32'(pop), 32'(1 << (k % 4)));
    end
`else
    // sources 0 and 3 busy: source 0 wins every time
    for (int k = 0; k < 4; k++) begin
      step(1'b1, ACT, 4'b0110, 4'h0, 4'h0);
      chk("fp_seq", 32'(pop), 32'd1);
    end
    step(1'b1, ACT, 4'b0111, 4'h0, 4'h0);
    chk("fp_src3", 32'(pop), 32'b1000);
`endif

    // only source 2 busy, then a 3-cycle stall
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ACT, 4'b1011, 4'h0, 4'h0);
      chk("src2_only", 32'(pop), 32'b0100);
    end
    step(1'b1, ACT, 4'b1011, 4'b0010, 4'h0);
    chk("stall_inflight", 32'(|push), 32'd1);
    chk("stall_nopop", 32'(pop), 32'd0);
    step(1'b1, ACT, 4'b1011, 4'b0010, 4'h0);
    chk("stall_nopop", 32'(pop), 32'd0);
    step(1'b1, ACT, 4'b1011, 4'b0010, 4'h0);
    chk("stall_nopop", 32'(pop), 32'd0);
    step(1'b1, ACT, 4'b1011, 4'h0, 4'h0);
    step(1'b1, ACT, 4'b1011, 4'h0, 4'h0);
    chk("resume_pop", 32'(pop), 32'b0100);

    // state leaves active right after a pop
    step(1'b1, ACT, 4'b1011, 4'h0, 4'h0);
    step(1'b1, 4'b0001, 4'b1011, 4'h0, 4'h0);
    chk("leave_push", 32'(|push), 32'd1);
    chk("leave_nopop", 32'(pop), 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'b0001, 4'b1011, 4'h0, 4'h0);
      chk("off_nopop", 32'(pop), 32'd0);
      chk("off_nopush", 32'(push), 32'd0);
    end

    // reset between pop and push drops the word; first grant after is source 0
    step(1'b1, ACT, 4'h0, 4'h0, 4'h0);
    step(1'b1, ACT, 4'h0, 4'h0, 4'h0);
    chk("pre_rst_pop", 32'(|pop), 32'd1);
    step(1'b0, ACT, 4'h0, 4'h0, 4'h0);
    chk("rst_drop_push", 32'(push), 32'd0);
    step(1'b1, ACT, 4'h0, 4'h0, 4'h0);
    chk("post_rst_push", 32'(push), 32'd0);
    step(1'b1, ACT, 4'h0, 4'h0, 4'h0);
    chk("post_rst_grant0", 32'(pop), 32'd1);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic rl;
      logic [3:0] st, es, af, ed;
      rl = ($urandom_range(0, 99) != 0);
      st = ($urandom_range(0, 9) < 8) ? ACT : 4'($urandom_range(0, 15));
      for (int b = 0; b < NS; b++) es[b] = ($urandom_range(0, 9) < 4);
      af = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
      ed = 4'($urandom);
      step(rl, st, es, af, ed);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
